uart_tx_fifo: RTL and testbench

- Byte FIFO with transmit handshake. Sits between split_data, which produces output bytes, and uart_tx, which serialises them.
- Absorbs bursts from the demod chain while uart_tx is busy, and launches one byte per uart_tx frame.
- Reports fill level, full/empty and a sticky overflow flag.

---
 rtl/fm_demod_pkg.sv | 13 +
 rtl/fifo_mem_dp.sv | 40 ++++
 rtl/uart_tx_fifo.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_demod_pkg.sv
// rtl/fm_demod_pkg.sv - shared constants and types for the demod output path
package fm_demod_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_fifo_state_t;

endpackage

// File: rtl/fifo_mem_dp.sv
// rtl/fifo_mem_dp.sv - byte register array, synchronous write, registered read
module fifo_mem_dp
    import fm_demod_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [BYTE_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [BYTE_W-1:0] o_rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [BYTE_W-1:0] r_rd_data;

    // Storage write; entries are only read after being written, so no reset
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read that holds its value between reads (read-before-write)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO with uart_tx launch handshake (option: UART_TX_FIFO_OVF_CNT_EN)
module uart_tx_fifo
    import fm_demod_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] wr_data_i,
    input  logic              wr_valid_i,
    input  logic              tx_busy_i,
    output logic [BYTE_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o,
    output logic              overflow_o
`ifdef UART_TX_FIFO_OVF_CNT_EN
    ,
    output logic [15:0]       ovf_cnt_o
`endif
);

    localparam int                TMO_W      = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(BUSY_TIMEOUT - 1);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_CNT    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_PTR    = ADDR_W'(1);

    tx_fifo_state_t    r_state;
    tx_fifo_state_t    w_state_next;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_count_next;
    logic              r_full;
    logic              r_empty;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic              w_pop;
    logic              w_tmo_clr;
    logic              w_tmo_inc;
    logic              w_wr_accept;
    logic              w_drop;
    logic [BYTE_W-1:0] w_rd_data;

    // A pop frees a slot in the same edge, so a write at full still lands
    assign w_wr_accept = wr_valid_i && (!r_full || w_pop);
    assign w_drop      = wr_valid_i && !w_wr_accept;

    fifo_mem_dp #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wr_data_i),
        .i_rd_en   (w_pop),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Launch FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Launch FSM: pop on IDLE->LAUNCH, then wait for uart_tx to take and finish the frame
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_tmo_clr    = 1'b0;
        w_tmo_inc    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_empty && !tx_busy_i) begin
                    w_pop        = 1'b1;
                    w_state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                w_tmo_clr    = 1'b1;
                w_state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy_i) begin
                    w_state_next = WAIT_DONE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_next = IDLE;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_i) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Counter of cycles spent waiting for tx_busy_i to rise after a launch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_tmo_clr) begin
            r_tmo_cnt <= '0;
        end else if (w_tmo_inc) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    // Next entry count; simultaneous write and pop leaves it unchanged
    always_comb begin
        w_count_next = r_count;
        if (w_wr_accept && !w_pop) begin
            w_count_next = r_count + ONE_CNT;
        end else if (!w_wr_accept && w_pop) begin
            w_count_next = r_count - ONE_CNT;
        end
    end

    // Pointers wrap naturally; count and its full/empty decodes are registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + ONE_PTR;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ONE_PTR;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_COUNT);
            r_empty <= (w_count_next == '0);
        end
    end

`ifdef UART_TX_FIFO_OVF_CNT_EN
    logic [15:0] r_ovf_cnt;

    // Saturating count of dropped writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_cnt <= '0;
        end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

    assign ovf_cnt_o  = r_ovf_cnt;
    assign overflow_o = (r_ovf_cnt != 16'd0);
`else
    logic r_overflow;

    // Sticky dropped-write flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow_o = r_overflow;
`endif

    assign tx_data_o  = w_rd_data;
    assign tx_valid_o = (r_state == LAUNCH);
    assign full_o     = r_full;
    assign empty_o    = r_empty;
    assign level_o    = r_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo against a queue model
module tb_uart_tx_fifo;

    localparam int DEPTH        = 16;
    localparam int ADDR_W       = 4;
    localparam int BUSY_TIMEOUT = 4;
    localparam int NEVER        = 1 << 30;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        wr_data_i;
    logic              wr_valid_i;
    logic              tx_busy_i;
    logic [7:0]        tx_data_o;
    logic              tx_valid_o;
    logic              full_o;
    logic              empty_o;
    logic [ADDR_W:0]   level_o;
    logic              overflow_o;
`ifdef UART_TX_FIFO_OVF_CNT_EN
    logic [15:0]       ovf_cnt_o;
`endif

    uart_tx_fifo #(
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_data_i  (wr_data_i),
        .wr_valid_i (wr_valid_i),
        .tx_busy_i  (tx_busy_i),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .level_o    (level_o),
        .overflow_o (overflow_o)
`ifdef UART_TX_FIFO_OVF_CNT_EN
        ,
        .ovf_cnt_o  (ovf_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: byte queue plus the launch rules expressed as cycle timestamps
    logic [7:0] m_q[$];
    logic [7:0] m_data;
    bit         m_valid;
    bit         m_ovf;
    int         m_ovf_cnt;
    int         m_ready_at;
    int         m_launch_at;
    int         m_rise_at;

    int         launch_cyc[$];
    logic [7:0] launch_byte[$];

    int u_start = -100;
    int u_len   = 0;

    function automatic void model_reset();
        m_q.delete();
        m_data      = 8'h00;
        m_valid     = 1'b0;
        m_ovf       = 1'b0;
        m_ovf_cnt   = 0;
        m_ready_at  = 0;
        m_launch_at = -100;
        m_rise_at   = -1;
    endfunction

    // Advance the model through cycle t; results describe outputs after the closing edge
    function automatic void model_step(int t, bit w, logic [7:0] d, bit b);
        bit pop;
        if (m_ready_at > t) begin
            if (m_rise_at < 0) begin
                if (t > m_launch_at && b) m_rise_at = t;
                else if (t == m_launch_at + BUSY_TIMEOUT) m_ready_at = t + 1;
            end else if (t > m_rise_at && !b) begin
                m_ready_at = t + 1;
            end
        end
        pop = (t >= m_ready_at) && (m_q.size() > 0) && !b;
        m_valid = pop;
        if (pop) begin
            m_data      = m_q.pop_front();
            m_launch_at = t + 1;
            m_ready_at  = NEVER;
            m_rise_at   = -1;
        end
        if (w) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(d);
            end else begin
                m_ovf = 1'b1;
                if (m_ovf_cnt < 65535) m_ovf_cnt++;
            end
        end
    endfunction

    function automatic bit u_busy(int t);
        return (t >= u_start) && (t < u_start + u_len);
    endfunction

    task automatic chk_reset_values(input string tag);
        chk({tag, "_tx_valid"}, tx_valid_o, 0);
        chk({tag, "_tx_data"}, tx_data_o, 0);
        chk({tag, "_level"}, level_o, 0);
        chk({tag, "_full"}, full_o, 0);
        chk({tag, "_empty"}, empty_o, 1);
        chk({tag, "_overflow"}, overflow_o, 0);
`ifdef UART_TX_FIFO_OVF_CNT_EN
        chk({tag, "_ovf_cnt"}, ovf_cnt_o, 0);
`endif
    endtask

    // One clock cycle: drive inputs, step the model, then compare every output after the edge
    task automatic cycle(input bit w, input logic [7:0] d, input bit b);
        wr_valid_i = w;
        wr_data_i  = d;
        tx_busy_i  = b;
        model_step(cyc, w, d, b);
        @(posedge clk);
        #1;
        cyc++;
        chk("tx_valid", tx_valid_o, m_valid);
        chk("tx_data", tx_data_o, m_data);
        chk("level", level_o, m_q.size());
        chk("full", full_o, m_q.size() == DEPTH);
        chk("empty", empty_o, m_q.size() == 0);
        chk("overflow", overflow_o, m_ovf);
`ifdef UART_TX_FIFO_OVF_CNT_EN
        chk("ovf_cnt", ovf_cnt_o, m_ovf_cnt);
`endif
        if (tx_valid_o) begin
            launch_cyc.push_back(cyc);
            launch_byte.push_back(tx_data_o);
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge
    task automatic do_reset(input string tag);
        #3;
        rst        = 1'b1;
        wr_valid_i = 1'b0;
        tx_busy_i  = 1'b0;
        #1;
        chk_reset_values(tag);
        model_reset();
        u_start = -100;
        u_len   = 0;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        launch_cyc.delete();
        launch_byte.delete();
    endtask

    // uart_tx stand-in: after each launch, busy rises after a short delay for one frame
    task automatic run_uart(input int n, input int wr_pct, input int miss_pct,
                            input int max_dly, input int min_len, input int max_len);
        bit         w;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            w = ($urandom_range(99) < wr_pct);
            d = 8'($urandom_range(255));
            cycle(w, d, u_busy(cyc));
            if (tx_valid_o && ($urandom_range(99) >= miss_pct)) begin
                u_start = cyc + 1 + int'($urandom_range(max_dly));
                u_len   = int'($urandom_range(max_len, min_len));
            end
        end
    endtask

    int n0;

    initial begin
        rst        = 1'b1;
        wr_valid_i = 1'b0;
        wr_data_i  = 8'h00;
        tx_busy_i  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_values("init");

        // Single byte into an empty FIFO with uart_tx idle
        repeat (8) cycle(0, 8'h00, 0);
        n0 = cyc;
        cycle(1, 8'hA5, 0);
        repeat (8) cycle(0, 8'h00, 0);
        chk("single_launches", launch_cyc.size(), 1);
        if (launch_cyc.size() == 1) begin
            chk("single_latency", launch_cyc[0], n0 + 2);
            chk("single_byte", launch_byte[0], 8'hA5);
        end
        chk("single_level", level_o, 0);

        // Burst while busy, then one dropped write, then drain
        launch_cyc.delete();
        launch_byte.delete();
        for (int i = 1; i <= 16; i++) cycle(1, 8'(i), 1);
        chk("burst_level", level_o, 16);
        chk("burst_full", full_o, 1);
        chk("burst_ovf_clear", overflow_o, 0);
        cycle(1, 8'h11, 1);
        chk("burst_ovf_set", overflow_o, 1);
        run_uart(200, 0, 0, 0, 5, 5);
        chk("burst_launches", launch_byte.size(), 16);
        for (int i = 0; i < 16 && i < launch_byte.size(); i++) begin
            chk("burst_order", launch_byte[i], 8'(i + 1));
        end

        // Reset mid-cycle with bytes stored and overflow set
        for (int i = 0; i < 5; i++) cycle(1, 8'(8'h40 + i), 1);
        do_reset("midrst");

        // Write and pop in the same cycle while full
        for (int i = 0; i < 16; i++) cycle(1, 8'(8'h20 + i), 1);
        launch_cyc.delete();
        launch_byte.delete();
        cycle(1, 8'h55, 0);
        chk("wp_level", level_o, 16);
        chk("wp_full", full_o, 1);
        chk("wp_ovf", overflow_o, 0);
        u_start = cyc + 1;
        u_len   = 3;
        run_uart(250, 0, 0, 1, 2, 4);
        chk("wp_launches", launch_byte.size(), 17);
        if (launch_byte.size() == 17) begin
            chk("wp_first", launch_byte[0], 8'h20);
            chk("wp_last", launch_byte[16], 8'h55);
        end

        // uart_tx never raises busy: launches fall back on the timeout
        do_reset("tmo_rst");
        cycle(1, 8'hC1, 0);
        cycle(1, 8'hC2, 0);
        cycle(1, 8'hC3, 0);
        repeat (25) cycle(0, 8'h00, 0);
        chk("tmo_launches", launch_cyc.size(), 3);
        if (launch_cyc.size() == 3) begin
            chk("tmo_gap1", launch_cyc[1] - launch_cyc[0], 6);
            chk("tmo_gap2", launch_cyc[2] - launch_cyc[1], 6);
            chk("tmo_byte3", launch_byte[2], 8'hC3);
        end

`ifdef UART_TX_FIFO_OVF_CNT_EN
        // Dropped-write counter
        do_reset("cnt_rst");
        for (int i = 0; i < 16; i++) cycle(1, 8'(i), 1);
        for (int i = 0; i < 20; i++) cycle(1, 8'hEE, 1);
        chk("cnt_value", ovf_cnt_o, 20);
        chk("cnt_flag", overflow_o, 1);
        do_reset("cnt_clear");
`endif

        // Randomized traffic: light load, then heavy load with overflows and missed frames
        do_reset("rand_rst");
        run_uart(600, 15, 10, 2, 1, 6);
        run_uart(1200, 50, 20, 2, 1, 8);
        run_uart(300, 0, 0, 2, 1, 4);
        chk("rand_drained", empty_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
